// File: rtl/fibo_pkg.sv
// rtl/fibo_pkg.sv - shared types and constants for the Fibonacci generator and capture stage
package fibo_pkg;

    // Register width of the generator; the capture stage sees sums of FIBO_WIDTH+1 bits.
    localparam int FIBO_WIDTH = 4;

    // Drop counter width and its saturation value.
    localparam int                DROP_W   = 8;
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    // Capture FSM: RUN accepts samples, HALT ignores them until reset.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

endpackage

// File: rtl/fibo_fifo.sv
// rtl/fibo_fifo.sv - parameterised show-ahead FIFO
//
// Ports:
//   clk    in   rising-edge clock
//   resetn in   synchronous active-low reset (clears pointers and count only)
//   push   in   write din this edge (ignored when full unless pop frees a slot)
//   pop    in   advance head this edge (ignored when empty)
//   din    in   DW-bit write data
//   dout   out  DW-bit head entry, 0 when empty
//   full   out  DEPTH entries held
//   empty  out  0 entries held
//   count  out  occupancy, $clog2(DEPTH)+1 bits
module fibo_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DW-1:0]              din,
    output logic [DW-1:0]              dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = pop & ~w_empty;
    // A pop in the same edge frees the slot the push needs.
    assign w_do_push = push & (~w_full | w_do_pop);

    // Storage is deliberately not reset; empty-gating on dout hides stale data.
    always_ff @(posedge clk) begin
        if (w_do_push && resetn) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign full  = w_full;
    assign empty = w_empty;
    assign count = r_count;

endmodule

// File: rtl/fibo_capture.sv
// rtl/fibo_capture.sv - capture stage tagging generator sums with a term index
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-low reset
//   en         in   sample data_in this edge
//   data_in    in   WIDTH+1-bit generator sum
//   out_valid  out  head entry available
//   out_ready  in   consumer takes head this edge
//   out_data   out  head sample, 0 when empty
//   out_idx    out  head term index, 0 when empty
//   full       out  FIFO holds DEPTH entries
//   empty      out  FIFO holds no entries
//   drop_cnt   out  saturating count of samples rejected while full
//   seq_wrap   out  sticky: a captured sample had bit WIDTH set
//   halted     out  FSM in HALT
module fibo_capture
    import fibo_pkg::*;
#(
    parameter int WIDTH         = FIBO_WIDTH,
    parameter int DEPTH         = 4,
    parameter int IDX_W         = 8,
    parameter int STOP_ON_CARRY = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [WIDTH:0]    data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH:0]    out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              full,
    output logic              empty,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              seq_wrap,
    output logic              halted
);

    localparam int DW = IDX_W + WIDTH + 1;
    localparam int CW = $clog2(DEPTH) + 1;

    state_t            r_state;
    logic              r_halted;
    logic [IDX_W-1:0]  r_idx_cnt;
    logic [DROP_W-1:0] r_drop_cnt;
    logic              r_seq_wrap;

    logic [DW-1:0]     w_dout;
    logic              w_full;
    logic              w_empty;
    logic [CW-1:0]     w_count;
    logic              w_has_room;
    logic              w_run;
    logic              w_en_run;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic              w_carry;

    assign w_run      = (r_state == ST_RUN);
    assign w_en_run   = en & w_run;
    assign w_has_room = (w_count != CW'(DEPTH));
    assign w_pop      = ~w_empty & out_ready;
    assign w_push     = w_en_run & (w_has_room | w_pop);
    assign w_drop     = w_en_run & ~w_has_room & ~w_pop;
    assign w_carry    = data_in[WIDTH];

    fibo_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (reset),
        .push   (w_push),
        .pop    (w_pop),
        .din    ({r_idx_cnt, data_in}),
        .dout   (w_dout),
        .full   (w_full),
        .empty  (w_empty),
        .count  (w_count)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_RUN;
            r_halted   <= 1'b0;
            r_idx_cnt  <= '0;
            r_drop_cnt <= '0;
            r_seq_wrap <= 1'b0;
        end else begin
            // Index advances on every accepted strobe so drops appear as gaps.
            if (w_en_run) begin
                r_idx_cnt <= r_idx_cnt + IDX_W'(1);
            end
            if (w_drop && (r_drop_cnt != DROP_MAX)) begin
                r_drop_cnt <= r_drop_cnt + DROP_W'(1);
            end
            if (w_push && w_carry) begin
                r_seq_wrap <= 1'b1;
            end
            case (r_state)
                ST_RUN: begin
                    if ((STOP_ON_CARRY != 0) && w_push && w_carry) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end
                end
                ST_HALT: begin
                    r_state  <= ST_HALT;
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state  <= ST_RUN;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = ~w_empty;
    assign out_data  = w_dout[WIDTH:0];
    assign out_idx   = w_dout[DW-1:WIDTH+1];
    assign full      = w_full;
    assign empty     = w_empty;
    assign drop_cnt  = r_drop_cnt;
    assign seq_wrap  = r_seq_wrap;
    assign halted    = r_halted;

endmodule

// File: tb/tb_fibo_capture.sv
// tb/tb_fibo_capture.sv - directed self-checking bench for fibo_capture
module tb_fibo_capture;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int IDX_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic [WIDTH:0]   data_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_data;
    logic [IDX_W-1:0] out_idx;
    logic             full;
    logic             empty;
    logic [7:0]       drop_cnt;
    logic             seq_wrap;
    logic             halted;

    int n_pass  = 0;
    int n_total = 0;
    int fib [7] = '{1, 1, 2, 3, 5, 8, 13};

    always #5 clk = ~clk;

    fibo_capture #(
        .WIDTH         (WIDTH),
        .DEPTH         (DEPTH),
        .IDX_W         (IDX_W),
        .STOP_ON_CARRY (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .full      (full),
        .empty     (empty),
        .drop_cnt  (drop_cnt),
        .seq_wrap  (seq_wrap),
        .halted    (halted)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic do_reset();
        reset = 1'b0; en = 1'b0; out_ready = 1'b0; data_in = '0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data",  32'(out_data), 0);
        check("rst_idx",   32'(out_idx), 0);
        check("rst_full",  32'(full), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_drop",  32'(drop_cnt), 0);
        check("rst_wrap",  32'(seq_wrap), 0);
        check("rst_halt",  32'(halted), 0);

        // Basic stream: every sample appears one cycle later
        out_ready = 1'b1; en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            data_in = 5'(fib[i]);
            step();
            check("bs_valid", 32'(out_valid), 1);
            check("bs_data",  32'(out_data), 32'(fib[i]));
            check("bs_idx",   32'(out_idx), 32'(i));
        end
        en = 1'b0;
        step();
        check("bs_empty", 32'(empty), 1);
        check("bs_drop",  32'(drop_cnt), 0);

        // Fill and drain
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            data_in = 5'(fib[i]);
            step();
            if (i == 2) check("fd_full3", 32'(full), 0);
            if (i == 3) check("fd_full4", 32'(full), 1);
        end
        check("fd_drop", 32'(drop_cnt), 2);
        en = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("fd_data", 32'(out_data), 32'(fib[i]));
            check("fd_idx",  32'(out_idx), 32'(i));
            step();
        end
        check("fd_empty", 32'(empty), 1);
        check("fd_valid", 32'(out_valid), 0);
        check("fd_zero",  32'(out_data), 0);

        // Push and pop while full
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_in = 5'(fib[i]);
            step();
        end
        out_ready = 1'b1; data_in = 5'd5;
        step();
        check("pp_full", 32'(full), 1);
        check("pp_drop", 32'(drop_cnt), 0);
        check("pp_head", 32'(out_idx), 1);
        en = 1'b0;
        step();
        check("pp_idx2", 32'(out_idx), 2);
        step();
        check("pp_idx3", 32'(out_idx), 3);
        step();
        check("pp_idx4",  32'(out_idx), 4);
        check("pp_data4", 32'(out_data), 5);

        // Overflow halt
        do_reset();
        en = 1'b1; data_in = 5'd13;
        step();
        check("oh_wrap0", 32'(seq_wrap), 0);
        data_in = 5'd21;
        step();
        check("oh_wrap", 32'(seq_wrap), 1);
        check("oh_halt", 32'(halted), 1);
        data_in = 5'd7;
        for (int i = 0; i < 5; i++) step();
        check("oh_drop", 32'(drop_cnt), 0);
        check("oh_full", 32'(full), 0);
        en = 1'b0; out_ready = 1'b1;
        check("oh_d0",  32'(out_data), 13);
        check("oh_i0",  32'(out_idx), 0);
        step();
        check("oh_d1",  32'(out_data), 21);
        check("oh_i1",  32'(out_idx), 1);
        step();
        check("oh_empty", 32'(empty), 1);

        // Reset mid-burst with 3 entries, one drop, wrap and halt set
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_in = 5'(fib[i]);
            step();
        end
        data_in = 5'd8;
        step();
        check("rm_drop1", 32'(drop_cnt), 1);
        en = 1'b0; out_ready = 1'b1;
        step(); step();
        out_ready = 1'b0; en = 1'b1; data_in = 5'd21;
        step();
        check("rm_wrap1", 32'(seq_wrap), 1);
        check("rm_halt1", 32'(halted), 1);
        check("rm_head",  32'(out_idx), 2);
        reset = 1'b0; out_ready = 1'b1; data_in = 5'd9;
        step();
        check("rm_empty", 32'(empty), 1);
        check("rm_valid", 32'(out_valid), 0);
        check("rm_drop",  32'(drop_cnt), 0);
        check("rm_wrap",  32'(seq_wrap), 0);
        check("rm_halt",  32'(halted), 0);
        reset = 1'b1; out_ready = 1'b0;
        step();
        check("rm_idx0",  32'(out_idx), 0);
        check("rm_data9", 32'(out_data), 9);

        // Drop saturation: fill remaining 3 slots then hold en
        data_in = 5'd3;
        step(); step(); step();
        check("ds_full", 32'(full), 1);
        for (int i = 0; i < 300; i++) begin
            step();
            if (i == 253) check("ds_254", 32'(drop_cnt), 254);
            if (i == 254) check("ds_255", 32'(drop_cnt), 255);
        end
        check("ds_sat",  32'(drop_cnt), 255);
        check("ds_idx",  32'(out_idx), 0);
        check("ds_data", 32'(out_data), 9);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
